tap_delay_line: RTL and testbench
=================================

// Module: tap_delay_line
// PURPOSE
//  Parametrised registered input delay line: WIDTH-bit samples shift through DEPTH stages.
//  A runtime tap select picks which stage drives the output.
//  Adds stall, flush, per-tap valid tracking and a change-detect mode.
//  Sits between the dedicated input pins and downstream logic; supplies delayed or edge-marked copies.
// PARAMETERS
//  WIDTH   8  sample width in bits
//  DEPTH   7  number of delay stages (>=2)
//  TAP_W   4  width of tap_sel; must be >= $clog2(DEPTH)
// PORTS
//  clk      in   1      clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  en       in   1      shift enable; stages advance on each edge where en=1 and freeze=0
//  freeze   in   1      hold all stages and the fill count (stall)
//  flush    in   1      synchronous clear of stages and fill count
//  mode     in   1      0 = delayed sample, 1 = change detect
//  tap_sel  in   TAP_W  stage index driving dout
//  din      in   WIDTH  input sample
//  dout     out  WIDTH  selected tap output
//  valid    out  1      selected tap holds real data since last reset/flush
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stages=0, fill=0; dout=0, valid=0 immediately; no clock needed.
//  - shift = en & ~freeze.
//  - On shift: stage[0]<=din and stage[k]<=stage[k-1] for k=1..DEPTH-1.
//  - On shift: fill <= min(fill+1, DEPTH), saturating.
//  - fill width = $clog2(DEPTH+1).
//  - freeze=1: stages and fill hold regardless of en.
//  - flush=1: next edge sets all stages=0 and fill=0.
//    Flush has priority over shift and freeze; a din presented that cycle is discarded.
//  - tap_eff = (tap_sel >= DEPTH) ? DEPTH-1 : tap_sel (clamp, no wrap).
//  - dout is combinational from registered state only (no din feedthrough).
//    mode=0: dout = stage[tap_eff].
//    mode=1: dout = stage[0] ^ stage[tap_eff]; tap_eff=0 gives 0.
//  - Latency, continuous shifting, mode=0: din sampled at edge E appears on dout after edge E+tap_eff.
//    tap 0 is therefore one register of delay.
//  - valid = (fill > tap_eff). valid is combinational from fill and tap_sel, so a tap_sel change
//    re-evaluates immediately.
//  - mode and tap_sel may change on any cycle; dout reflects the new selection with no stage
//    disturbance.
//  - Stage contents never depend on mode or tap_sel.
//  - Reset mid-stream discards all history; the first post-reset shift behaves as from power-up.
// TESTING
//  1. Reset, en=1, tap_sel=0, din=0xA5 for one edge -> dout=0xA5, valid=1 after that edge;
//     dout=0, valid=0 before it.
//  2. tap_sel=6, din=0x01..0x07 on successive edges -> valid rises after 7th edge with dout=0x01;
//     8th edge gives dout=0x02.
//  3. Mid-stream freeze=1 for 3 edges, din changing -> dout and valid constant.
//     After release the sequence resumes with no lost or duplicated sample.
//  4. flush=1 with en=1, din=0xFF -> next edge all stages 0, dout=0, valid=0 for every tap_sel.
//  5. DEPTH=7, tap_sel=9 -> identical dout/valid to tap_sel=6.
//  6. mode=1, tap_sel=3, steady 0x3C, then step to 0xC3 -> dout=0xFF for 3 edges, then 0x00.
//     Also: rst_n low mid-stream -> dout=0, valid=0 with no clock edge.

Source files
------------

// File: rtl/tap_delay_line.sv
// Registered input delay line with runtime tap select, stall, flush and change detection.
// Output is purely combinational from registered state and the current tap/mode selection.
module tap_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 7,
    parameter int unsigned TAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             freeze,
    input  logic             flush,
    input  logic             mode,
    input  logic [TAP_W-1:0] tap_sel,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    localparam int unsigned FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FillMax = FILL_W'(DEPTH);

    logic [WIDTH-1:0]  stage_q [DEPTH];
    logic [WIDTH-1:0]  stage_d [DEPTH];
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              shift;
    logic [31:0]       tap_ext;
    logic [31:0]       tap_eff;
    logic [WIDTH-1:0]  tap_data;

    assign shift = en & ~freeze;

    // Flush wins over both shift and freeze.
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = '0;
            end
            fill_d = '0;
        end else if (shift) begin
            stage_d[0] = din;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (fill_q != FillMax) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            fill_q <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
        end
    end

    // Out-of-range selects clamp to the last stage rather than wrapping.
    always_comb begin
        tap_ext = 32'(tap_sel);
        tap_eff = (tap_ext >= DEPTH) ? (DEPTH - 1) : tap_ext;
    end

    always_comb begin
        tap_data = stage_q[DEPTH-1];
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_eff == 32'(k)) begin
                tap_data = stage_q[k];
            end
        end
    end

    assign dout  = mode ? (stage_q[0] ^ tap_data) : tap_data;
    assign valid = (32'(fill_q) > tap_eff);

endmodule

// File: tb/tb_tap_delay_line.sv
// Self-checking bench for tap_delay_line: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based history model.
module tb_tap_delay_line;

    localparam int W  = 8;
    localparam int D  = 7;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en, freeze, flush, mode;
    logic [TW-1:0] tap_sel;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
    logic          valid;

    int errors = 0;
    int checks = 0;

    // Samples shifted in since the last reset/flush, oldest first, newest last.
    logic [W-1:0] hist[$];

    typedef struct {
        logic         en;
        logic         freeze;
        logic         flush;
        logic         mode;
        logic [3:0]   tap;
        logic [7:0]   din;
        logic [7:0]   exp_dout;
        logic         exp_valid;
    } vec_t;

    vec_t vecs[$];

    tap_delay_line #(
        .WIDTH(W),
        .DEPTH(D),
        .TAP_W(TW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .freeze (freeze),
        .flush  (flush),
        .mode   (mode),
        .tap_sel(tap_sel),
        .din    (din),
        .dout   (dout),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int clamp_tap(input int t);
        return (t >= D) ? D - 1 : t;
    endfunction

    function automatic logic [W-1:0] sample_ago(input int k);
        if (k < hist.size()) return hist[hist.size() - 1 - k];
        return '0;
    endfunction

    function automatic logic [W-1:0] model_dout(input logic m, input int t);
        int te = clamp_tap(t);
        if (m) return sample_ago(0) ^ sample_ago(te);
        return sample_ago(te);
    endfunction

    function automatic logic model_valid(input int t);
        int filled = (hist.size() < D) ? hist.size() : D;
        return filled > clamp_tap(t);
    endfunction

    task automatic model_edge();
        if (flush) begin
            hist.delete();
        end else if (en && !freeze) begin
            hist.push_back(din);
            if (hist.size() > D) void'(hist.pop_front());
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".dout"}, 32'(dout), 32'(model_dout(mode, int'(tap_sel))));
        check({tag, ".valid"}, 32'(valid), 32'(model_valid(int'(tap_sel))));
    endtask

    task automatic add(input logic e, input logic fz, input logic fl, input logic m,
                       input logic [3:0] t, input logic [7:0] d, input logic [7:0] ed,
                       input logic ev);
        vec_t v;
        v.en = e; v.freeze = fz; v.flush = fl; v.mode = m; v.tap = t; v.din = d;
        v.exp_dout = ed; v.exp_valid = ev;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; freeze = 1'b0; flush = 1'b0; mode = 1'b0;
        tap_sel = '0; din = '0;
        #2;
        check("reset.dout", 32'(dout), 32'h0);
        check("reset.valid", 32'(valid), 32'h0);
        #1 rst_n = 1'b1;

        // en freeze flush mode tap din -> dout valid
        add(1, 0, 0, 0, 0, 8'hA5, 8'hA5, 1);
        add(1, 0, 1, 0, 6, 8'hFF, 8'h00, 0);
        for (int i = 1; i <= 6; i++) add(1, 0, 0, 0, 6, 8'(i), 8'h00, 0);
        add(1, 0, 0, 0, 6, 8'h07, 8'h01, 1);
        add(1, 0, 0, 0, 6, 8'h08, 8'h02, 1);
        add(1, 1, 0, 0, 6, 8'h55, 8'h02, 1);
        add(1, 1, 0, 0, 6, 8'h66, 8'h02, 1);
        add(0, 1, 0, 0, 6, 8'h77, 8'h02, 1);
        add(1, 0, 0, 0, 6, 8'h09, 8'h03, 1);
        add(0, 0, 0, 0, 9, 8'hEE, 8'h03, 1);
        add(0, 0, 0, 0, 3, 8'hEE, 8'h06, 1);
        add(0, 0, 0, 1, 3, 8'hEE, 8'h0F, 1);
        add(0, 0, 0, 1, 0, 8'hEE, 8'h00, 1);
        add(1, 0, 1, 0, 6, 8'hFF, 8'h00, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 3, 8'h3C, 8'h00, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 3, 8'h3C, 8'h3C, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 3, 8'hC3, 8'hFF, 1);
        add(1, 0, 0, 1, 3, 8'hC3, 8'h00, 1);
        add(1, 1, 1, 0, 0, 8'h44, 8'h00, 0);
        add(1, 1, 0, 0, 0, 8'h11, 8'h00, 0);

        foreach (vecs[i]) begin
            en = vecs[i].en; freeze = vecs[i].freeze; flush = vecs[i].flush;
            mode = vecs[i].mode; tap_sel = vecs[i].tap; din = vecs[i].din;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d.valid", i), 32'(valid), 32'(vecs[i].exp_valid));
        end

        // Flushed line: every tap select reads zero and invalid, no clock needed.
        en = 1'b0; freeze = 1'b0; flush = 1'b0; mode = 1'b0;
        for (int t = 0; t < 16; t++) begin
            tap_sel = 4'(t);
            #1;
            check($sformatf("flushed.tap%0d.dout", t), 32'(dout), 32'h0);
            check($sformatf("flushed.tap%0d.valid", t), 32'(valid), 32'h0);
        end

        // Asynchronous reset in the middle of a stream.
        en = 1'b1; tap_sel = 4'd1; din = 8'h5A;
        @(posedge clk);
        #1 din = 8'h6B;
        @(posedge clk);
        #1;
        check("pre_rst.dout", 32'(dout), 32'h5A);
        check("pre_rst.valid", 32'(valid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst.dout", 32'(dout), 32'h0);
        check("async_rst.valid", 32'(valid), 32'h0);
        #1 rst_n = 1'b1;
        tap_sel = 4'd0; din = 8'h77;
        @(posedge clk);
        #1;
        check("post_rst.tap0.dout", 32'(dout), 32'h77);
        check("post_rst.tap0.valid", 32'(valid), 32'h1);
        tap_sel = 4'd1;
        #1;
        check("post_rst.tap1.dout", 32'(dout), 32'h0);
        check("post_rst.tap1.valid", 32'(valid), 32'h0);

        // Randomized traffic against the history model, starting from a flush.
        hist.delete();
        hist.push_back(8'h77);
        en = 1'b0; flush = 1'b1;
        @(posedge clk);
        model_edge();
        #1 flush = 1'b0;
        for (int c = 0; c < 600; c++) begin
            en      = ($urandom_range(99) < 70);
            freeze  = ($urandom_range(99) < 15);
            flush   = ($urandom_range(99) < 4);
            mode    = 1'($urandom_range(1));
            tap_sel = 4'($urandom_range(15));
            din     = 8'($urandom);
            @(posedge clk);
            model_edge();
            #1;
            check_model($sformatf("rand%0d.edge", c));
            mode    = 1'($urandom_range(1));
            tap_sel = 4'($urandom_range(15));
            #1;
            check_model($sformatf("rand%0d.sel", c));
            if ($urandom_range(99) < 2) begin
                rst_n = 1'b0;
                hist.delete();
                #1;
                check_model($sformatf("rand%0d.rst", c));
                rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
